mfd_trans_seg: RTL and testbench

Request segmenter directly upstream of `mfd_trans`. Accepts one host transfer request at a time (start LBA, sector count, tag) and emits a stream of fabric-sized segments. Each segment is bounded by a maximum burst length and never crosses an aligned LBA boundary. `mfd_trans` consumes the segments and issues them onto the MSI fabric through `msi_fabric_if`.

---
 rtl/mfd_trans_seg_if.sv | 30 +++
 rtl/mfd_trans_seg.sv | 148 ++++++++++++++
 tb/tb_mfd_trans_seg.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfd_trans_seg_if.sv
// Request/segment bus between the host request source, mfd_trans_seg and mfd_trans.
// master = environment side (drives requests, consumes segments); slave = segmenter.
interface mfd_trans_seg_if #(
  parameter int LBA_W = 48,
  parameter int CNT_W = 16,
  parameter int TAG_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [LBA_W-1:0] req_lba;
  logic [CNT_W-1:0] req_cnt;
  logic [TAG_W-1:0] req_tag;
  logic             seg_valid;
  logic             seg_ready;
  logic [LBA_W-1:0] seg_lba;
  logic [CNT_W-1:0] seg_cnt;
  logic [TAG_W-1:0] seg_tag;
  logic             seg_last;
  logic             err_zero;

  modport master (
    output req_valid, req_lba, req_cnt, req_tag, seg_ready,
    input  req_ready, seg_valid, seg_lba, seg_cnt, seg_tag, seg_last, err_zero
  );

  modport slave (
    input  req_valid, req_lba, req_cnt, req_tag, seg_ready,
    output req_ready, seg_valid, seg_lba, seg_cnt, seg_tag, seg_last, err_zero
  );
endinterface

// File: rtl/mfd_trans_seg.sv
// Splits one host transfer request into MAX_SEG-bounded, boundary-aligned segments for mfd_trans.
// Optional statistics counters are enabled with the MFD_TRANS_SEG_STATS_EN macro.
module mfd_trans_seg #(
  parameter int LBA_W    = 48,
  parameter int CNT_W    = 16,
  parameter int TAG_W    = 8,
  parameter int MAX_SEG  = 64,
  parameter int BND_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
`ifdef MFD_TRANS_SEG_STATS_EN
  input  logic                stat_clr,
  output logic [31:0]         stat_req_cnt,
  output logic [31:0]         stat_seg_cnt,
`endif
  mfd_trans_seg_if.slave      bus
);

  localparam logic [CNT_W:0] BND_SZ = (CNT_W+1)'(1) << BND_LOG2;
  localparam logic [CNT_W:0] MAX_L  = (CNT_W+1)'(MAX_SEG);

  typedef enum logic {S_IDLE, S_SEG} state_t;

  state_t           r_state;
  logic [LBA_W-1:0] r_cur_lba;
  logic [CNT_W-1:0] r_rem;
  logic [TAG_W-1:0] r_tag;
  logic             r_req_ready;
  logic             r_seg_valid;
  logic [CNT_W-1:0] r_seg_cnt;
  logic             r_seg_last;
  logic             r_err_zero;

  logic [LBA_W-1:0] w_nxt_lba;
  logic [CNT_W-1:0] w_nxt_rem;
  logic [LBA_W-1:0] w_len_lba;
  logic [CNT_W-1:0] w_len_rem;
  logic [CNT_W-1:0] w_len;
  logic             w_acc_nz;
  logic             w_seg_hs;

  // len = min(rem, MAX_SEG, distance to next aligned boundary), held in CNT_W+1 bits
  function automatic logic [CNT_W-1:0] seg_len(input logic [BND_LOG2-1:0] lba_lo,
                                               input logic [CNT_W-1:0]    rem);
    logic [CNT_W:0] to_bnd;
    logic [CNT_W:0] len;
    to_bnd = BND_SZ - {{(CNT_W+1-BND_LOG2){1'b0}}, lba_lo};
    len    = {1'b0, rem};
    if (MAX_L < len)  len = MAX_L;
    if (to_bnd < len) len = to_bnd;
    return len[CNT_W-1:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One length calculator serves both the first segment (from the request) and the following ones
  assign w_nxt_lba = r_cur_lba + {{(LBA_W-CNT_W){1'b0}}, r_seg_cnt};
  assign w_nxt_rem = r_rem - r_seg_cnt;
  assign w_len_lba = (r_state == S_IDLE) ? bus.req_lba : w_nxt_lba;
  assign w_len_rem = (r_state == S_IDLE) ? bus.req_cnt : w_nxt_rem;
  assign w_len     = seg_len(w_len_lba[BND_LOG2-1:0], w_len_rem);

  assign w_acc_nz  = (r_state == S_IDLE) && bus.req_valid && (bus.req_cnt != '0);
  assign w_seg_hs  = r_seg_valid && bus.seg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_lba   <= '0;
      r_rem       <= '0;
      r_tag       <= '0;
      r_req_ready <= 1'b1;
      r_seg_valid <= 1'b0;
      r_seg_cnt   <= '0;
      r_seg_last  <= 1'b0;
      r_err_zero  <= 1'b0;
    end else begin
      r_err_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_cur_lba <= bus.req_lba;
            r_rem     <= bus.req_cnt;
            r_tag     <= bus.req_tag;
            if (bus.req_cnt == '0) begin
              r_err_zero <= 1'b1;
            end else begin
              r_state     <= S_SEG;
              r_req_ready <= 1'b0;
              r_seg_valid <= 1'b1;
              r_seg_cnt   <= w_len;
              r_seg_last  <= (bus.req_cnt == w_len);
            end
          end
        end
        S_SEG: begin
          if (bus.seg_ready) begin
            if (r_seg_last) begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
              r_seg_valid <= 1'b0;
            end else begin
              r_cur_lba  <= w_nxt_lba;
              r_rem      <= w_nxt_rem;
              r_seg_cnt  <= w_len;
              r_seg_last <= (w_nxt_rem == w_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.seg_valid = r_seg_valid;
  assign bus.seg_lba   = r_cur_lba;
  assign bus.seg_cnt   = r_seg_cnt;
  assign bus.seg_tag   = r_tag;
  assign bus.seg_last  = r_seg_last;
  assign bus.err_zero  = r_err_zero;

`ifdef MFD_TRANS_SEG_STATS_EN
  logic [31:0] r_stat_req;
  logic [31:0] r_stat_seg;

  // Clear takes priority over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      r_stat_req <= '0;
      r_stat_seg <= '0;
    end else begin
      if (w_acc_nz) r_stat_req <= sat_inc(r_stat_req);
      if (w_seg_hs) r_stat_seg <= sat_inc(r_stat_seg);
    end
  end

  assign stat_req_cnt = r_stat_req;
  assign stat_seg_cnt = r_stat_seg;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_acc_nz ^ w_seg_hs ^ (|sat_inc(32'd0));
`endif

endmodule

// File: tb/tb_mfd_trans_seg.sv
// Scoreboard bench for mfd_trans_seg: a reference segmenter model queues expected segments,
// a negedge monitor pops and compares each handshaked segment.
module tb_mfd_trans_seg;
  localparam int LBA_W = 48;
  localparam int CNT_W = 16;
  localparam int TAG_W = 8;

  typedef struct packed {
    logic [LBA_W-1:0] lba;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag;
    logic             last;
  } seg_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  seg_t sb[$];

`ifdef MFD_TRANS_SEG_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_req_cnt;
  logic [31:0] stat_seg_cnt;
`endif

  mfd_trans_seg_if #(.LBA_W(LBA_W), .CNT_W(CNT_W), .TAG_W(TAG_W)) bus ();

  mfd_trans_seg #(
    .LBA_W(LBA_W), .CNT_W(CNT_W), .TAG_W(TAG_W), .MAX_SEG(64), .BND_LOG2(6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef MFD_TRANS_SEG_STATS_EN
    .stat_clr     (stat_clr),
    .stat_req_cnt (stat_req_cnt),
    .stat_seg_cnt (stat_seg_cnt),
`endif
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.seg_valid && bus.seg_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_seg got lba=%h cnt=%0d tag=%h last=%b, none expected",
                 bus.seg_lba, bus.seg_cnt, bus.seg_tag, bus.seg_last);
      end else begin
        seg_t e;
        e = sb.pop_front();
        if ({bus.seg_lba, bus.seg_cnt, bus.seg_tag, bus.seg_last} !== e) begin
          errors++;
          $display("FAIL seg got lba=%h cnt=%0d tag=%h last=%b, expected lba=%h cnt=%0d tag=%h last=%b",
                   bus.seg_lba, bus.seg_cnt, bus.seg_tag, bus.seg_last,
                   e.lba, e.cnt, e.tag, e.last);
        end
      end
    end
  end

  // Reference segmenter: MAX_SEG=64, 64-sector aligned boundaries
  task automatic model_push(input logic [LBA_W-1:0] lba, input logic [CNT_W-1:0] cnt,
                            input logic [TAG_W-1:0] tag);
    logic [LBA_W-1:0] l;
    int rem, len, to_bnd;
    l   = lba;
    rem = int'(cnt);
    while (rem > 0) begin
      to_bnd = 64 - int'(l[5:0]);
      len    = rem;
      if (len > 64)     len = 64;
      if (len > to_bnd) len = to_bnd;
      sb.push_back('{lba: l, cnt: CNT_W'(len), tag: tag, last: (rem == len)});
      l   = l + LBA_W'(len);
      rem = rem - len;
    end
  endtask

  // Leaves the bench just after the accepting clock edge
  task automatic send_req(input logic [LBA_W-1:0] lba, input logic [CNT_W-1:0] cnt,
                          input logic [TAG_W-1:0] tag);
    bit rdy;
    rdy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin rdy = 1; break; end
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout got req_ready=0, expected 1");
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_lba   = lba;
    bus.req_cnt   = cnt;
    bus.req_tag   = tag;
    model_push(lba, cnt, tag);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.req_ready) begin done = 1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d req_ready=%b, expected pending=0 req_ready=1",
               name, sb.size(), bus.req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.seg_valid, bus.req_ready, bus.err_zero, bus.seg_last} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_ctrl got valid/ready/errz/last=%b%b%b%b, expected 0100",
               bus.seg_valid, bus.req_ready, bus.err_zero, bus.seg_last);
    end
    checks++;
    if (bus.seg_lba !== '0 || bus.seg_cnt !== '0 || bus.seg_tag !== '0) begin
      errors++;
      $display("FAIL reset_data got lba=%h cnt=%0d tag=%h, expected 0 0 0",
               bus.seg_lba, bus.seg_cnt, bus.seg_tag);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    send_req(48'h10, 16'd10, 8'hA5);
    @(negedge clk);
    checks++;
    if (bus.seg_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_latency got valid=%b ready=%b, expected valid=1 ready=0",
               bus.seg_valid, bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_back got ready=%b valid=%b, expected ready=1 valid=0",
               bus.req_ready, bus.seg_valid);
    end
    wait_idle("single");
  endtask

  task automatic test_boundary();
    send_req(48'd60, 16'd10, 8'h11);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.seg_valid !== 1'b1 || bus.seg_lba !== 48'd64) begin
      errors++;
      $display("FAIL boundary_consec got valid=%b lba=%h, expected valid=1 lba=40",
               bus.seg_valid, bus.seg_lba);
    end
    wait_idle("boundary");
  endtask

  task automatic test_multi();
    send_req(48'd0, 16'd200, 8'h3C);
    wait_idle("multi");
  endtask

  task automatic test_wrap();
    send_req(48'hFFFF_FFFF_FFFE, 16'd4, 8'h77);
    wait_idle("wrap");
  endtask

  task automatic test_backpressure();
    send_req(48'd0, 16'd200, 8'h5A);
    @(posedge clk); #1;
    bus.seg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.seg_valid, bus.seg_lba, bus.seg_cnt, bus.seg_tag, bus.seg_last} !==
          {1'b1, 48'd64, 16'd64, 8'h5A, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got valid=%b lba=%h cnt=%0d last=%b, expected 1 40 64 0",
                 i, bus.seg_valid, bus.seg_lba, bus.seg_cnt, bus.seg_last);
      end
    end
    @(posedge clk); #1;
    bus.seg_ready = 1'b1;
    wait_idle("bp");
    send_req(48'h123, 16'd0, 8'h99);
    @(negedge clk);
    checks++;
    if ({bus.err_zero, bus.req_ready, bus.seg_valid} !== 3'b110) begin
      errors++;
      $display("FAIL zero_pulse got errz/ready/valid=%b%b%b, expected 110",
               bus.err_zero, bus.req_ready, bus.seg_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.err_zero, bus.seg_valid} !== 2'b00) begin
      errors++;
      $display("FAIL zero_single_cycle got errz/valid=%b%b, expected 00",
               bus.err_zero, bus.seg_valid);
    end
  endtask

  task automatic test_reset_mid();
    send_req(48'd0, 16'd200, 8'h42);
    @(posedge clk); #1;
    bus.seg_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.seg_valid, bus.req_ready, bus.err_zero} !== 3'b010 || bus.seg_cnt !== '0 ||
        bus.seg_lba !== '0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b ready=%b cnt=%0d lba=%h, expected 0 1 0 0",
               bus.seg_valid, bus.req_ready, bus.seg_cnt, bus.seg_lba);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.seg_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet got valid=%b, expected 0", bus.seg_valid);
    end
`ifdef MFD_TRANS_SEG_STATS_EN
    checks++;
    if (stat_req_cnt !== 32'd0 || stat_seg_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset got req=%0d seg=%0d, expected 0 0", stat_req_cnt, stat_seg_cnt);
    end
`endif
  endtask

`ifdef MFD_TRANS_SEG_STATS_EN
  task automatic test_stats();
    send_req(48'd0, 16'd200, 8'h01);
    wait_idle("stats");
    checks++;
    if (stat_req_cnt !== 32'd1 || stat_seg_cnt !== 32'd4) begin
      errors++;
      $display("FAIL stats_count got req=%0d seg=%0d, expected 1 4", stat_req_cnt, stat_seg_cnt);
    end
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (stat_req_cnt !== 32'd0 || stat_seg_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_clr got req=%0d seg=%0d, expected 0 0", stat_req_cnt, stat_seg_cnt);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_lba   = '0;
    bus.req_cnt   = '0;
    bus.req_tag   = '0;
    bus.seg_ready = 1'b1;
`ifdef MFD_TRANS_SEG_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_boundary();
    test_multi();
    test_wrap();
    test_backpressure();
    test_reset_mid();
`ifdef MFD_TRANS_SEG_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
